seg_pwm_scanner: RTL and testbench

Parametrised successor of the single-byte segment/PWM combiner. It latches a DATA_W-bit value and shows it as hex on DIGITS time-multiplexed seven-segment digits, with optional leading-zero blanking, a per-digit decimal point and anti-ghost blanking. It also generates a glitch-free PWM output whose duty comes from the top bits of the same value. It sits between switch/register logic and the board display/LED pins.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/hex7seg_dec.sv | 9 +
 rtl/seg_pwm_scanner.sv | 93 +++++++++
 tb/tb_seg_pwm_scanner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: active-low seven-segment constants and hex lookup table
package seg_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] HEX_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: combinational nibble to active-low {g..a} segment decoder
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_LUT[nib_i];
endmodule

// File: rtl/seg_pwm_scanner.sv
// seg_pwm_scanner: multiplexed hex display with leading-zero/anti-ghost blanking and glitch-free PWM
module seg_pwm_scanner
  import seg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int PWM_W = 8,
  parameter int PWM_DIV = 1,
  localparam int DIGITS = DATA_W / 4
) (
  input  logic              sys_clk_pin,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic [DIGITS-1:0] dp,
  input  logic              lz_blank,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              pwm,
  output logic              frame_tick
);
  localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int PRE_W = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;

  logic [DATA_W-1:0] val_q;
  logic [DIGITS-1:0] dp_q, an_q, an_d;
  logic              lz_q, pwm_q, pwm_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [PWM_W-1:0]  pcnt_q, pcnt_d, duty_q, duty_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        nib;
  logic [6:0]        dec;
  logic              cnt_end, blank, lz_hide, step;

  hex7seg_dec u_dec (.nib_i(nib), .seg_o(dec));

  always_comb begin
    cnt_end = cnt_q == CNT_W'(SCAN_DIV - 1);
    cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
    idx_d = !cnt_end ? idx_q : idx_q == IDX_W'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    nib = 4'(val_q >> {idx_q, 2'b00});
    // a digit hides only when it and every more-significant nibble are zero
    lz_hide = lz_q && idx_q != '0 && (val_q >> {idx_q, 2'b00}) == '0;
    blank = cnt_q < CNT_W'(BLANK_CYC);
    seg_d = blank ? 8'hFF : {~dp_q[idx_q], lz_hide ? SEG_OFF : dec};
    an_d = blank ? '1 : ~(DIGITS'(1) << idx_q);
    step = pre_q == PRE_W'(PWM_DIV - 1);
    pre_d = step ? '0 : pre_q + 1'b1;
    pcnt_d = step ? pcnt_q + 1'b1 : pcnt_q;
    // duty only changes at the period boundary so a period is never cut short
    duty_d = step && pcnt_q == '1 ? val_q[DATA_W-1 -: PWM_W] : duty_q;
    pwm_d = pcnt_q < duty_q;
  end

  always_ff @(posedge sys_clk_pin) begin
    if (rst) begin
      val_q <= '0;
      dp_q <= '0;
      lz_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      pre_q <= '0;
      pcnt_q <= '0;
      duty_q <= '0;
      seg_q <= 8'hFF;
      an_q <= '1;
      pwm_q <= 1'b0;
    end else begin
      if (load) begin
        val_q <= value;
        dp_q <= dp;
        lz_q <= lz_blank;
      end
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      pcnt_q <= pcnt_d;
      duty_q <= duty_d;
      seg_q <= seg_d;
      an_q <= an_d;
      pwm_q <= pwm_d;
    end
  end

  assign seg = seg_q;
  assign an = an_q;
  assign pwm = pwm_q;
  assign frame_tick = cnt_end && idx_q == IDX_W'(DIGITS - 1);
endmodule

// File: tb/tb_seg_pwm_scanner.sv
// tb_seg_pwm_scanner: table-driven display frames and PWM sequences checked through expectation queues
module tb_seg_pwm_scanner;
  logic        sys_clk_pin = 1'b0;
  logic        rst = 1'b1, load = 1'b0, lz_blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0, an;
  logic [7:0]  seg;
  logic        pwm, frame_tick;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [15:0]     v;
    logic [3:0]      d;
    logic            lz;
    logic [3:0][6:0] e;
  } vec_t;
  vec_t vecs [7];
  logic [11:0] disp_q [$];
  logic        pwm_q [$];
  logic [7:0]  cnt_q [$];

  seg_pwm_scanner #(.DATA_W(16), .SCAN_DIV(8), .BLANK_CYC(2), .PWM_W(4), .PWM_DIV(1)) dut (
    .sys_clk_pin(sys_clk_pin), .rst(rst), .value(value), .load(load), .dp(dp),
    .lz_blank(lz_blank), .seg(seg), .an(an), .pwm(pwm), .frame_tick(frame_tick)
  );

  always #5 sys_clk_pin = ~sys_clk_pin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk_pin);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    value = v; dp = d; lz_blank = lz; load = 1'b1;
    @(negedge sys_clk_pin);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge sys_clk_pin);
      ok = frame_tick;
    end
    chk("frame_timeout", 32'(ok), 32'd1);
  endtask

  task automatic check_frame(input string name, input logic [3:0] d, input logic [3:0][6:0] e);
    int ft = 0;
    wait_frame();
    for (int k = 0; k < 32; k++)
      disp_q.push_back(k % 8 < 2 ? 12'hFFF : {~(4'b1 << (k / 8)), ~d[k / 8], e[k / 8]});
    @(negedge sys_clk_pin);
    for (int k = 0; k < 32; k++) begin
      @(negedge sys_clk_pin);
      ft += int'(frame_tick);
      chk($sformatf("%s_c%0d", name, k), {20'h0, an, seg}, {20'h0, disp_q.pop_front()});
    end
    chk({name, "_ticks"}, ft, 1);
  endtask

  task automatic pwm_duty(input logic [15:0] v, input int exp);
    int hi = 0;
    do_load(v, 4'h0, 1'b0);
    cyc(40);
    cnt_q.push_back(8'(exp));
    for (int i = 0; i < 16; i++) begin
      @(negedge sys_clk_pin);
      hi += int'(pwm);
    end
    chk($sformatf("pwm_%h", v), hi, 32'(cnt_q.pop_front()));
  endtask

  initial begin
    bit found = 0;
    logic prev;
    int hi = 0;
    vecs[0] = '{16'h1A3F, 4'b0100, 1'b0, {7'h79, 7'h08, 7'h30, 7'h0E}};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vecs[2] = '{16'h0005, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}};
    vecs[3] = '{16'h0050, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    vecs[4] = '{16'h0000, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[5] = '{16'h8B0C, 4'b0000, 1'b1, {7'h00, 7'h03, 7'h40, 7'h46}};
    vecs[6] = '{16'hD2E6, 4'b1111, 1'b0, {7'h21, 7'h24, 7'h06, 7'h02}};

    cyc(3);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 4'hF);
    chk("rst_pwm", pwm, 0);
    chk("rst_tick", frame_tick, 0);
    rst = 1'b0;
    cyc(1); chk("post_rst_an0", an, 4'hF);
    cyc(1); chk("post_rst_an1", an, 4'hF);
    cyc(1); chk("post_rst_an2", an, 4'hE);

    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].v, vecs[i].d, vecs[i].lz);
      check_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].e);
    end

    pwm_duty(16'h4123, 4);
    pwm_duty(16'h0FFF, 0);
    pwm_duty(16'hF000, 15);
    pwm_duty(16'h8000, 8);

    do_load(16'h4000, 4'h0, 1'b0);
    cyc(40);
    prev = pwm;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge sys_clk_pin);
      found = !prev && pwm;
      prev = pwm;
    end
    chk("pwm_rise_timeout", 32'(found), 1);
    cyc(4);
    value = 16'hC000; load = 1'b1;
    for (int j = 0; j < 27; j++)
      pwm_q.push_back(((5 + j) % 16) < ((5 + j) < 16 ? 4 : 12));
    for (int j = 0; j < 27; j++) begin
      @(negedge sys_clk_pin);
      load = 1'b0;
      chk($sformatf("pwm_mid_%0d", j), pwm, pwm_q.pop_front());
    end

    value = 16'hFFFF; dp = 4'hF; lz_blank = 1'b1; load = 1'b1; rst = 1'b1;
    @(negedge sys_clk_pin);
    rst = 1'b0; load = 1'b0;
    check_frame("rst_load", 4'h0, {7'h40, 7'h40, 7'h40, 7'h40});
    for (int i = 0; i < 32; i++) begin
      @(negedge sys_clk_pin);
      hi += int'(pwm);
    end
    chk("rst_load_pwm", hi, 0);

    value = 16'h1111; dp = 4'h0; lz_blank = 1'b0; load = 1'b1;
    @(negedge sys_clk_pin);
    value = 16'h2222;
    @(negedge sys_clk_pin);
    load = 1'b0;
    check_frame("last_load", 4'h0, {7'h24, 7'h24, 7'h24, 7'h24});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
